// File: rtl/miniled_pkg.sv
// Shared definitions for the mini-LED SDBP frame writer: pattern mode encodings,
// default frame timing and a width helper.
package miniled_pkg;

    typedef enum logic [1:0] {
        MODE_ALL   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_HALF  = 2'd2,
        MODE_THIRD = 2'd3
    } mode_e;

    localparam int unsigned DEF_CFG_DLY      = 2500;
    localparam int unsigned DEF_FRAME_PERIOD = 420000;
    localparam int unsigned DEF_WR_START     = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/miniled_pattern_gen.sv
// Combinational brightness-pattern generator: maps the write address, group
// position and running-light position to the data word for the current mode.
module miniled_pattern_gen
    import miniled_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned GROUP  = 24,
    parameter int unsigned GW     = 5
) (
    input  mode_e             mode_q,
    input  logic [DATA_W-1:0] level_q,
    input  logic [ADDR_W-1:0] addr,
    input  logic [GW-1:0]     grp,
    input  logic [ADDR_W-1:0] pos,
    output logic [DATA_W-1:0] data
);

    localparam logic [GW-1:0] GRP_HALF    = GW'(GROUP / 2);
    localparam logic [GW-1:0] GRP_THIRD   = GW'(GROUP / 3);
    localparam logic [GW-1:0] GRP_2THIRDS = GW'((2 * GROUP) / 3);

    always_comb begin
        data = '0;
        case (mode_q)
            MODE_ALL: data = level_q;
            MODE_RUN: data = (addr == pos) ? level_q : '0;
            MODE_HALF: data = (grp < GRP_HALF) ? level_q : '0;
            MODE_THIRD: begin
                if (grp < GRP_THIRD)
                    data = level_q;
                else if (grp < GRP_2THIRDS)
                    data = level_q >> 1;
                else
                    data = '0;
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/miniled_frame_writer.sv
// SDBP frame writer: waits out the register-configuration delay, then per frame
// pulses sdbpflag and streams one brightness write per LED into the driver RAM.
module miniled_frame_writer
    import miniled_pkg::*;
#(
    parameter int unsigned N_LED        = 360,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CFG_DLY      = DEF_CFG_DLY,
    parameter int unsigned FRAME_PERIOD = DEF_FRAME_PERIOD,
    parameter int unsigned FLAG_LEN     = 29,
    parameter int unsigned WR_START     = DEF_WR_START,
    parameter int unsigned HOLD_FRAMES  = 20,
    parameter int unsigned GROUP        = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] level,
    output logic              ready,
    output logic              sdbpflag,
    output logic              wtwe,
    output logic [ADDR_W-1:0] wtaddr,
    output logic [DATA_W-1:0] wtdina,
    output logic              frame_done
);

    localparam int unsigned CW = cnt_width(CFG_DLY);
    localparam int unsigned FW = cnt_width(FRAME_PERIOD);
    localparam int unsigned GW = cnt_width(GROUP);
    localparam int unsigned HW = cnt_width(HOLD_FRAMES);

    localparam logic [CW-1:0]     CFG_LAST   = CW'(CFG_DLY - 1);
    localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAME_PERIOD - 1);
    localparam logic [FW-1:0]     FLAG_LO    = FW'(1);
    localparam logic [FW-1:0]     FLAG_HI    = FW'(FLAG_LEN);
    localparam logic [FW-1:0]     WR_LO      = FW'(WR_START);
    localparam logic [FW-1:0]     WR_HI      = FW'(WR_START + N_LED - 1);
    localparam logic [FW-1:0]     DONE_AT    = FW'(WR_START + N_LED);
    localparam logic [GW-1:0]     GROUP_LAST = GW'(GROUP - 1);
    localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam logic [ADDR_W-1:0] POS_LAST   = ADDR_W'(N_LED - 1);

    logic [CW-1:0]     cfg_cnt;
    logic [FW-1:0]     fcnt;
    mode_e             mode_q;
    logic [DATA_W-1:0] level_q;
    logic [GW-1:0]     grp;
    logic [HW-1:0]     hcnt;
    logic [ADDR_W-1:0] pos;

    logic              in_win;
    logic [GW-1:0]     grp_cur;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] pat_data;

    // grp_cur is the group position of the write being prepared this cycle;
    // forcing 0 at the first write avoids a separate clear before the window.
    always_comb begin
        in_win   = ready && (fcnt >= WR_LO) && (fcnt <= WR_HI);
        grp_cur  = (fcnt == WR_LO) ? '0 : grp;
        addr_nxt = ADDR_W'(fcnt - WR_LO);
    end

    miniled_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .GROUP  (GROUP),
        .GW     (GW)
    ) u_pattern (
        .mode_q  (mode_q),
        .level_q (level_q),
        .addr    (addr_nxt),
        .grp     (grp_cur),
        .pos     (pos),
        .data    (pat_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cnt    <= '0;
            ready      <= 1'b0;
            fcnt       <= '0;
            mode_q     <= MODE_ALL;
            level_q    <= '0;
            grp        <= '0;
            hcnt       <= '0;
            pos        <= '0;
            sdbpflag   <= 1'b0;
            wtwe       <= 1'b0;
            wtaddr     <= '0;
            wtdina     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!ready) begin
                if (cfg_cnt == CFG_LAST)
                    ready <= 1'b1;
                else
                    cfg_cnt <= cfg_cnt + 1'b1;
            end

            if (ready)
                fcnt <= (fcnt == FRAME_LAST) ? '0 : fcnt + 1'b1;

            if (ready && (fcnt == '0)) begin
                mode_q  <= mode_e'(mode);
                level_q <= level;
            end

            sdbpflag   <= ready && (fcnt >= FLAG_LO) && (fcnt <= FLAG_HI);
            wtwe       <= in_win;
            wtaddr     <= in_win ? addr_nxt : '0;
            wtdina     <= in_win ? pat_data : '0;
            frame_done <= ready && (fcnt == DONE_AT);

            if (in_win)
                grp <= (grp_cur == GROUP_LAST) ? '0 : grp_cur + 1'b1;

            // Sweep advances in every mode so switching to MODE_RUN resumes it.
            if (frame_done) begin
                if (hcnt == HOLD_LAST) begin
                    hcnt <= '0;
                    pos  <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule
